xgmii_rx_frame_gen: RTL and testbench
=====================================

// Module: xgmii_rx_frame_gen
// PURPOSE
//  Link-partner transmitter for the xge_mac receive port: converts a packet stream (xge_mac pkt_* format) into
//  64-bit XGMII (start/preamble/SFD, data, terminate, idles). Replaces the xgmii_txd->xgmii_rxd loopback so the
//  bench drives MAC RX independently of MAC TX. No CRC generation: input frames carry their own FCS.
// PARAMETERS
//  IFG_WORDS  2  minimum all-idle XGMII words between a terminate word and the next start word (>=1)
// PORTS
//  clk_xgmii_rx      in   1   XGMII RX clock; only clock
//  reset_xgmii_rx_n  in   1   synchronous, active-low reset
//  in_val            in   1   input word valid
//  in_ready          out  1   word accepted when in_val & in_ready at posedge
//  in_data           in   64  packet bytes; [63:56] is first byte on the wire
//  in_sop            in   1   first word of packet
//  in_eop            in   1   last word of packet
//  in_mod            in   3   valid bytes in eop word; 0 = all 8
//  in_err            in   1   error-inject request on eop word (used only with macro, else ignored)
//  xgmii_rxd         out  64  XGMII data; lane i = [8i+7:8i], lane 0 first on wire
//  xgmii_rxc         out  8   XGMII control; bit i = 1 -> lane i is a control char
//  frame_cnt         out  16  frames terminated with /T/, wraps 0xFFFF->0
//  underrun          out  1   1-cycle pulse when an error word is emitted for input underrun
// BEHAVIOUR
//  - All outputs registered. Reset: xgmii_rxd=64'h0707070707070707, xgmii_rxc=8'hFF, in_ready=0,
//    frame_cnt=0, underrun=0, state=IDLE, IFG counter cleared (gap satisfied).
//  - Byte mapping: lane i <= in_data[63-8i -: 8]. Data lanes have rxc bit 0.
//  - FSM IDLE/START/DATA/TERM/DROP/IFG; outputs idle words (07, rxc=1) in every state not listed below.
//  - IDLE: in_ready=0 if in_val&in_sop, else 1 (non-sop words accepted and discarded). in_val&in_sop -> START.
//  - START: output start word: lane0=FB (ctl), lanes1-6=55, lane7=D5, rxc=8'h01; in_ready=1 -> DATA.
//  - DATA: in_ready=1; each accepted word appears on xgmii exactly 1 cycle after acceptance.
//    in_sop ignored mid-packet. eop mod=0: full data word, -> TERM. eop mod=m (1..7): lanes 0..m-1 data,
//    lane m=FD, lanes m+1..7=07, rxc=~((1<<m)-1) (e.g. m=5 -> 8'hE0); frame_cnt++; -> IFG.
//  - TERM: in_ready=0; output lane0=FD, lanes1-7=07, rxc=8'hFF; frame_cnt++; -> IFG.
//  - Underrun: in DATA with in_val=0 -> output all lanes FE, rxc=8'hFF, underrun=1 that cycle; frame_cnt unchanged;
//    -> DROP. DROP: in_ready=1, discard words until eop accepted, then -> IFG (eop in underrun cycle n/a: no word).
//  - IFG: in_ready=0; emit exactly IFG_WORDS idle words, then IDLE. Minimum sop-to-start delay from IDLE: 1 cycle;
//    back-to-back frames: exactly IFG_WORDS idle words between terminate/error-drop end and next start word.
//  - Reset asserted mid-frame: next edge outputs idle word, in_ready=0, no terminate emitted, frame_cnt=0.
//  - Simultaneous eop and reset: reset wins; frame not counted.
// CONFIGURATION
//  XGMII_RX_GEN_ERR_INJ_EN defined: eop word with in_err=1 emits FE (ctl) in place of FD in its terminate lane
//    (mod=0: TERM word lane0=FE); frame_cnt still increments. Undefined: in_err ignored, always FD.
// TESTING
//  1 16-byte pkt (2 words, eop mod=0) -> start word, 2 data words, FD/07 word rxc=FF, 2 idle words, frame_cnt=1
//  2 13-byte pkt (eop mod=5) -> last word lanes0-4 data, lane5=FD, lanes6-7=07, rxc=8'hE0; no TERM cycle
//  3 two pkts back-to-back, in_val held -> exactly IFG_WORDS idle words between terminate and second FB start
//  4 in_val low 1 cycle mid-pkt -> all-FE word rxc=FF, underrun pulse, rest dropped to eop, frame_cnt unchanged
//  5 reset mid-DATA -> idle word next cycle, in_ready=0, frame_cnt=0; following pkt framed normally
//  6 macro on, in_err=1 eop mod=3 -> lane3=FE, rxc=8'hF8; macro off same stimulus -> lane3=FD

Source files
------------

// File: rtl/xgmii_rx_frame_gen.sv
// xgmii_rx_frame_gen: packet stream to 64-bit XGMII link-partner transmitter; optional XGMII_RX_GEN_ERR_INJ_EN
module xgmii_rx_frame_gen #(
  parameter int IFG_WORDS = 2
) (
  input  logic        clk_xgmii_rx,
  input  logic        reset_xgmii_rx_n,
  input  logic        in_val,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic        in_sop,
  input  logic        in_eop,
  input  logic [2:0]  in_mod,
  input  logic        in_err,
  output logic [63:0] xgmii_rxd,
  output logic [7:0]  xgmii_rxc,
  output logic [15:0] frame_cnt,
  output logic        underrun
);
  localparam int GW = (IFG_WORDS > 1) ? $clog2(IFG_WORDS) : 1;
  localparam logic [63:0] IDLE_W = 64'h0707070707070707;
  localparam logic [63:0] START_W = 64'hD5555555555555FB;
  typedef enum logic [2:0] {IDLE, START, DATA, TERM, DROP, IFG} state_t;
  state_t state_q, state_d;
  logic [63:0] rxd_d;
  logic [7:0] rxc_d, tch;
  logic [15:0] cnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic ur_d, rdy_q, rdy_d, err_q, err_d, err_in;
`ifdef XGMII_RX_GEN_ERR_INJ_EN
  assign err_in = in_err;
`else
  logic unused_err;
  assign unused_err = in_err;
  assign err_in = 1'b0;
`endif
  assign tch = err_in ? 8'hFE : 8'hFD;
  // Sop is held off in IDLE so it is taken in START and lands right after the start word
  assign in_ready = rdy_q & ~((state_q == IDLE) & in_val & in_sop);
  function automatic logic [63:0] to_lanes(input logic [63:0] d);
    for (int i = 0; i < 8; i++) to_lanes[8*i +: 8] = d[63-8*i -: 8];
  endfunction
  // Next state and the XGMII word to be driven in the following cycle
  always_comb begin
    state_d = state_q;
    rxd_d = IDLE_W;
    rxc_d = 8'hFF;
    cnt_d = frame_cnt;
    ur_d = 1'b0;
    gap_d = gap_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (in_val && in_sop) begin
        state_d = START;
        rxd_d = START_W;
        rxc_d = 8'h01;
      end
      START, DATA: if (!in_val) begin
        rxd_d = {8{8'hFE}};
        ur_d = 1'b1;
        state_d = DROP;
      end else begin
        rxd_d = to_lanes(in_data);
        rxc_d = 8'h00;
        state_d = DATA;
        if (in_eop && in_mod == 3'd0) begin
          state_d = TERM;
          err_d = err_in;
        end else if (in_eop) begin
          for (int i = 0; i < 8; i++) begin
            if (i == int'(in_mod)) begin
              rxd_d[8*i +: 8] = tch;
              rxc_d[i] = 1'b1;
            end else if (i > int'(in_mod)) begin
              rxd_d[8*i +: 8] = 8'h07;
              rxc_d[i] = 1'b1;
            end
          end
          cnt_d = frame_cnt + 16'd1;
          state_d = IFG;
          gap_d = '0;
        end
      end
      TERM: begin
        rxd_d = {{7{8'h07}}, err_q ? 8'hFE : 8'hFD};
        cnt_d = frame_cnt + 16'd1;
        state_d = IFG;
        gap_d = '0;
      end
      DROP: if (in_val && in_eop) begin
        state_d = IFG;
        gap_d = '0;
      end
      IFG: if (gap_q == GW'(IFG_WORDS - 1)) state_d = IDLE; else gap_d = gap_q + GW'(1);
      default: state_d = IDLE;
    endcase
    rdy_d = (state_d != TERM) && (state_d != IFG);
  end
  // Register state and every output; reset drops any frame in flight without a terminate
  always_ff @(posedge clk_xgmii_rx) begin
    if (!reset_xgmii_rx_n) begin
      state_q <= IDLE;
      xgmii_rxd <= IDLE_W;
      xgmii_rxc <= 8'hFF;
      frame_cnt <= 16'd0;
      underrun <= 1'b0;
      rdy_q <= 1'b0;
      gap_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      xgmii_rxd <= rxd_d;
      xgmii_rxc <= rxc_d;
      frame_cnt <= cnt_d;
      underrun <= ur_d;
      rdy_q <= rdy_d;
      gap_q <= gap_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_xgmii_rx_frame_gen.sv
// tb_xgmii_rx_frame_gen: randomized self-checking bench against a wire-byte-stream reference model
module tb_xgmii_rx_frame_gen;
  localparam int IFG_WORDS = 2;
`ifdef XGMII_RX_GEN_ERR_INJ_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  localparam logic [71:0] IDLE_W = {8'hFF, 64'h0707070707070707};
  logic clk = 1'b0, rst_n = 1'b0, in_val = 1'b0, in_sop = 1'b0, in_eop = 1'b0, in_err = 1'b0;
  logic in_ready, underrun;
  logic [63:0] in_data = '0, xgmii_rxd;
  logic [2:0] in_mod = '0;
  logic [7:0] xgmii_rxc;
  logic [15:0] frame_cnt, exp_cnt = '0;
  int checks = 0, failures = 0, ur_seen = 0;
  logic [71:0] cap[$], exp_q[$], got[$];
  logic [7:0] drv[$], pkt[$];

  always #5 clk = ~clk;

  xgmii_rx_frame_gen #(.IFG_WORDS(IFG_WORDS)) dut (
    .clk_xgmii_rx(clk), .reset_xgmii_rx_n(rst_n), .in_val(in_val), .in_ready(in_ready),
    .in_data(in_data), .in_sop(in_sop), .in_eop(in_eop), .in_mod(in_mod), .in_err(in_err),
    .xgmii_rxd(xgmii_rxd), .xgmii_rxc(xgmii_rxc), .frame_cnt(frame_cnt), .underrun(underrun)
  );

  always @(negedge clk) begin
    cap.push_back({xgmii_rxc, xgmii_rxd});
    if (underrun) ur_seen++;
  end

  task automatic make_pkt(input int len);
    drv.delete();
    repeat (((len + 7) / 8) * 8) drv.push_back(8'($urandom));
    pkt = drv[0:len-1];
  endtask

  // Wire view: start sequence, payload bytes, terminate (or an FE word on underrun), 07 fill, 8 bytes per word
  task automatic model_pkt(input int ur_word, input bit err);
    logic [8:0] s[$];
    logic [71:0] w;
    s.push_back({1'b1, 8'hFB});
    repeat (6) s.push_back({1'b0, 8'h55});
    s.push_back({1'b0, 8'hD5});
    if (ur_word >= 0) begin
      for (int i = 0; i < 8 * (ur_word + 1); i++) s.push_back({1'b0, pkt[i]});
      repeat (8) s.push_back({1'b1, 8'hFE});
    end else begin
      foreach (pkt[i]) s.push_back({1'b0, pkt[i]});
      s.push_back({1'b1, (err && ERR_EN) ? 8'hFE : 8'hFD});
      while (s.size() % 8 != 0) s.push_back({1'b1, 8'h07});
      exp_cnt++;
    end
    for (int k = 0; k < s.size(); k += 8) begin
      for (int i = 0; i < 8; i++) begin
        w[64+i] = s[k+i][8];
        w[8*i +: 8] = s[k+i][7:0];
      end
      exp_q.push_back(w);
    end
  endtask

  task automatic drive_word(input int w, input int nw, input int len, input bit err, input bit wait_acc);
    int t = 0;
    @(negedge clk);
    in_val = 1'b1;
    in_sop = (w == 0);
    in_eop = (w == nw - 1);
    in_mod = 3'(len % 8);
    in_err = err && (w == nw - 1);
    for (int j = 0; j < 8; j++) in_data[63-8*j -: 8] = drv[8*w+j];
    if (!wait_acc) return;
    #4;
    while (!in_ready && t < 50) begin
      t++;
      @(negedge clk);
      #4;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout word=%0d in_ready=%b required=1", w, in_ready);
    end
  endtask

  task automatic send_pkt(input int len, input int ur_word, input bit err);
    int nw = (len + 7) / 8;
    make_pkt(len);
    for (int w = 0; w < nw; w++) begin
      drive_word(w, nw, len, err, 1'b1);
      if (w == ur_word) begin
        @(negedge clk);
        in_val = 1'b0;
      end
    end
    model_pkt(ur_word, err);
  endtask

  task automatic settle();
    @(negedge clk);
    in_val = 1'b0;
    in_sop = 1'b0;
    in_eop = 1'b0;
    in_err = 1'b0;
    repeat (IFG_WORDS + 6) @(negedge clk);
    got.delete();
    foreach (cap[i]) if (cap[i] !== IDLE_W) got.push_back(cap[i]);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks += 5;
    if (xgmii_rxd !== 64'h0707070707070707) begin failures++; $display("FAIL rst_rxd got=%h exp=0707070707070707", xgmii_rxd); end
    if (xgmii_rxc !== 8'hFF) begin failures++; $display("FAIL rst_rxc got=%h exp=ff", xgmii_rxc); end
    if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", in_ready); end
    if (frame_cnt !== 16'd0) begin failures++; $display("FAIL rst_cnt got=%0d exp=0", frame_cnt); end
    if (underrun !== 1'b0) begin failures++; $display("FAIL rst_underrun got=%b exp=0", underrun); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL idle_ready got=%b exp=1", in_ready); end
    exp_cnt = '0;
  endtask

  task automatic test_two_word();
    cap.delete();
    send_pkt(16, -1, 1'b0);
    settle();
    checks += 2;
    if (got.size() != 4) begin failures++; $display("FAIL two_word_count got=%0d exp=4", got.size()); end
    if (frame_cnt !== exp_cnt) begin failures++; $display("FAIL two_word_cnt got=%0d exp=%0d", frame_cnt, exp_cnt); end
    if (got.size() != exp_q.size()) begin checks++; failures++; $display("FAIL two_word_len got=%0d exp=%0d", got.size(), exp_q.size()); end
    else foreach (got[i]) begin
      checks++;
      if (got[i] !== exp_q[i]) begin failures++; $display("FAIL two_word_w%0d got=%h exp=%h", i, got[i], exp_q[i]); end
    end
    exp_q.delete();
  endtask

  task automatic test_mod5();
    cap.delete();
    send_pkt(13, -1, 1'b0);
    settle();
    checks += 2;
    if (got.size() != 3 || got[2][71:64] !== 8'hE0 || got[2][47:40] !== 8'hFD) begin
      failures++;
      $display("FAIL mod5_term got=%h exp_rxc=e0 lane5=fd words=3", got.size() > 2 ? got[2] : 72'h0);
    end
    if (frame_cnt !== exp_cnt) begin failures++; $display("FAIL mod5_cnt got=%0d exp=%0d", frame_cnt, exp_cnt); end
    if (got.size() != exp_q.size()) begin checks++; failures++; $display("FAIL mod5_len got=%0d exp=%0d", got.size(), exp_q.size()); end
    else foreach (got[i]) begin
      checks++;
      if (got[i] !== exp_q[i]) begin failures++; $display("FAIL mod5_w%0d got=%h exp=%h", i, got[i], exp_q[i]); end
    end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    int st[$];
    int last;
    cap.delete();
    send_pkt(16, -1, 1'b0);
    send_pkt(13, -1, 1'b0);
    send_pkt(20, -1, 1'b0);
    settle();
    foreach (cap[i]) if (cap[i][7:0] == 8'hFB && cap[i][64]) st.push_back(i);
    checks++;
    if (st.size() != 3) begin failures++; $display("FAIL b2b_starts got=%0d exp=3", st.size()); end
    for (int k = 1; k < st.size(); k++) begin
      last = -1;
      for (int i = 0; i < st[k]; i++) if (cap[i] !== IDLE_W) last = i;
      checks++;
      if (st[k] - last - 1 != IFG_WORDS) begin failures++; $display("FAIL b2b_gap%0d got=%0d exp=%0d", k, st[k] - last - 1, IFG_WORDS); end
    end
    checks++;
    if (frame_cnt !== exp_cnt) begin failures++; $display("FAIL b2b_cnt got=%0d exp=%0d", frame_cnt, exp_cnt); end
    if (got.size() != exp_q.size()) begin checks++; failures++; $display("FAIL b2b_len got=%0d exp=%0d", got.size(), exp_q.size()); end
    else foreach (got[i]) begin
      checks++;
      if (got[i] !== exp_q[i]) begin failures++; $display("FAIL b2b_w%0d got=%h exp=%h", i, got[i], exp_q[i]); end
    end
    exp_q.delete();
  endtask

  task automatic test_underrun();
    cap.delete();
    ur_seen = 0;
    send_pkt(32, 1, 1'b0);
    settle();
    checks += 2;
    if (ur_seen != 1) begin failures++; $display("FAIL ur_pulses got=%0d exp=1", ur_seen); end
    if (frame_cnt !== exp_cnt) begin failures++; $display("FAIL ur_cnt got=%0d exp=%0d", frame_cnt, exp_cnt); end
    if (got.size() != exp_q.size()) begin checks++; failures++; $display("FAIL ur_len got=%0d exp=%0d", got.size(), exp_q.size()); end
    else foreach (got[i]) begin
      checks++;
      if (got[i] !== exp_q[i]) begin failures++; $display("FAIL ur_w%0d got=%h exp=%h", i, got[i], exp_q[i]); end
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    cap.delete();
    make_pkt(24);
    drive_word(0, 3, 24, 1'b0, 1'b1);
    drive_word(1, 3, 24, 1'b0, 1'b1);
    drive_word(2, 3, 24, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    checks += 3;
    if ({xgmii_rxc, xgmii_rxd} !== IDLE_W) begin failures++; $display("FAIL rmid_word got=%h exp=%h", {xgmii_rxc, xgmii_rxd}, IDLE_W); end
    if (in_ready !== 1'b0) begin failures++; $display("FAIL rmid_ready got=%b exp=0", in_ready); end
    if (frame_cnt !== 16'd0) begin failures++; $display("FAIL rmid_cnt got=%0d exp=0", frame_cnt); end
    rst_n = 1'b1;
    in_val = 1'b0;
    exp_cnt = '0;
    model_pkt(1, 1'b0);
    void'(exp_q.pop_back());
    make_pkt(16);
    drive_word(0, 2, 16, 1'b0, 1'b1);
    drive_word(1, 2, 16, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_pkt(0, 1'b0);
    void'(exp_q.pop_back());
    send_pkt(21, -1, 1'b0);
    settle();
    checks++;
    if (frame_cnt !== exp_cnt) begin failures++; $display("FAIL rmid_after_cnt got=%0d exp=%0d", frame_cnt, exp_cnt); end
    if (got.size() != exp_q.size()) begin checks++; failures++; $display("FAIL rmid_len got=%0d exp=%0d", got.size(), exp_q.size()); end
    else foreach (got[i]) begin
      checks++;
      if (got[i] !== exp_q[i]) begin failures++; $display("FAIL rmid_w%0d got=%h exp=%h", i, got[i], exp_q[i]); end
    end
    exp_q.delete();
  endtask

  task automatic test_err();
    cap.delete();
    send_pkt(11, -1, 1'b1);
    send_pkt(16, -1, 1'b1);
    settle();
    checks += 2;
    if (got.size() < 3 || got[2][71:64] !== 8'hF8 || got[2][31:24] !== (ERR_EN ? 8'hFE : 8'hFD)) begin
      failures++;
      $display("FAIL err_mod3 got=%h exp_rxc=f8 lane3=%h", got.size() > 2 ? got[2] : 72'h0, ERR_EN ? 8'hFE : 8'hFD);
    end
    if (frame_cnt !== exp_cnt) begin failures++; $display("FAIL err_cnt got=%0d exp=%0d", frame_cnt, exp_cnt); end
    if (got.size() != exp_q.size()) begin checks++; failures++; $display("FAIL err_len got=%0d exp=%0d", got.size(), exp_q.size()); end
    else foreach (got[i]) begin
      checks++;
      if (got[i] !== exp_q[i]) begin failures++; $display("FAIL err_w%0d got=%h exp=%h", i, got[i], exp_q[i]); end
    end
    exp_q.delete();
  endtask

  task automatic test_random();
    int exp_ur = 0;
    cap.delete();
    ur_seen = 0;
    for (int p = 0; p < 24; p++) begin
      int len = $urandom_range(1, 40);
      int nw = (len + 7) / 8;
      int ur = (nw >= 2 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, nw - 2)) : -1;
      if ($urandom_range(0, 3) == 0) begin
        int t = 0;
        @(negedge clk);
        in_val = 1'b1;
        in_sop = 1'b0;
        in_eop = 1'b0;
        in_data = {$urandom, $urandom};
        #4;
        while (!in_ready && t < 50) begin t++; @(negedge clk); #4; end
      end
      if (ur >= 0) exp_ur++;
      send_pkt(len, ur, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        in_val = 1'b0;
      end
    end
    settle();
    checks += 2;
    if (ur_seen != exp_ur) begin failures++; $display("FAIL rnd_ur got=%0d exp=%0d", ur_seen, exp_ur); end
    if (frame_cnt !== exp_cnt) begin failures++; $display("FAIL rnd_cnt got=%0d exp=%0d", frame_cnt, exp_cnt); end
    if (got.size() != exp_q.size()) begin checks++; failures++; $display("FAIL rnd_len got=%0d exp=%0d", got.size(), exp_q.size()); end
    else foreach (got[i]) begin
      checks++;
      if (got[i] !== exp_q[i]) begin failures++; $display("FAIL rnd_w%0d got=%h exp=%h", i, got[i], exp_q[i]); end
    end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_two_word();
    test_mod5();
    test_back_to_back();
    test_underrun();
    test_reset_mid();
    test_err();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
